// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv_n_m convolution engine.
// No ports: imported by the engine, its MAC stage and its sample memories.
package conv_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   // Bits needed to index n entries (values 0..n-1); never less than one bit.
   // cw(N), cw(M) and cw(N-M+1) give the x-address, f-address and output-index widths.
   function automatic int cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_n_m_if.sv
// Stream bundle for conv_n_m: x-sample and f-coefficient inputs, y output,
// each with a valid/ready handshake.
//   slave  : engine side (consumes x/f, produces y)
//   master : source/sink side (produces x/f, consumes y)
interface conv_n_m_if #(
   parameter int DW = 8,
   parameter int OW = 18
);
   logic [DW-1:0] s_data_in_x;
   logic          s_valid_x;
   logic          s_ready_x;
   logic [DW-1:0] s_data_in_f;
   logic          s_valid_f;
   logic          s_ready_f;
   logic [OW-1:0] m_data_out_y;
   logic          m_valid_y;
   logic          m_ready_y;

   modport slave (
      input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
      output s_ready_x, s_ready_f, m_data_out_y, m_valid_y
   );

   modport master (
      output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
      input  s_ready_x, s_ready_f, m_data_out_y, m_valid_y
   );
endinterface

// File: rtl/conv_mac.sv
// Signed multiply-accumulate stage with optional ReLU on its result.
//   clk, reset : clock and asynchronous active-high reset
//   en         : a/b hold a valid product term this cycle
//   clr        : first term of a new output (replaces the running sum)
//   a, b       : signed DW-bit operands
//   y          : accumulator, clamped at 0 when RELU != 0 and it is negative
module conv_mac #(
   parameter int DW   = 8,
   parameter int OW   = 18,
   parameter int RELU = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [OW-1:0] y
);
   logic signed [2*DW-1:0] prod;
   logic signed [OW-1:0]   prod_ext;
   logic signed [OW-1:0]   acc;

   always_comb begin
      prod     = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
      prod_ext = OW'(prod);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc <= '0;
      else if (en) acc <= clr ? prod_ext : acc + prod_ext;
   end

   assign y = (RELU != 0 && acc[OW-1]) ? '0 : acc;
endmodule

// File: rtl/sp_mem.sv
// Single-port memory with a registered read (1-cycle read latency).
//   clk   : rising-edge clock
//   we    : write enable (writes wdata at addr)
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data of addr
module sp_mem
   import conv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SIZE  = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [cw(SIZE)-1:0]   addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);
   logic [WIDTH-1:0] mem [SIZE];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/conv_n_m.sv
// Valid-mode 1-D convolution: loads N x samples and M f taps, then streams
// N-M+1 outputs y[i] = sum_j x[i+j]*f[j]; frames run back-to-back.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, discards any partial frame
//   bus   : conv_n_m_if slave (x/f inputs, y output, all registered outputs)
module conv_n_m
   import conv_pkg::*;
#(
   parameter int DW   = 8,
   parameter int N    = 8,
   parameter int M    = 4,
   parameter int OW   = 2*DW + $clog2(M),
   parameter int RELU = 0
) (
   input logic        clk,
   input logic        reset,
   conv_n_m_if.slave  bus
);
   localparam int XAW = cw(N);
   localparam int FAW = cw(M);
   localparam int XCW = cw(N+1);
   localparam int FCW = cw(M+1);
   localparam int IW  = cw(N-M+1);
   localparam int SW  = cw(M+2);

   localparam logic [XCW-1:0] X_FULL = XCW'(N);
   localparam logic [FCW-1:0] F_FULL = FCW'(M);
   localparam logic [IW-1:0]  I_LAST = IW'(N-M);
   localparam logic [SW-1:0]  S_TAPS = SW'(M);
   localparam logic [SW-1:0]  S_DONE = SW'(M+1);

   state_t         state;
   logic [XCW-1:0] xcnt, xcnt_n;
   logic [FCW-1:0] fcnt, fcnt_n;
   logic [IW-1:0]  idx;
   logic [SW-1:0]  step;
   logic           x_fire, f_fire;
   logic [XAW-1:0] x_addr;
   logic [FAW-1:0] f_addr;
   logic [DW-1:0]  x_rd, f_rd;
   logic           rd_v, rd_clr;
   logic [OW-1:0]  mac_y;

   // Readies are only ever high in LOAD, so memory writes are confined to LOAD.
   assign x_fire = bus.s_valid_x & bus.s_ready_x;
   assign f_fire = bus.s_valid_f & bus.s_ready_f;

   always_comb begin
      xcnt_n = xcnt + XCW'(x_fire);
      fcnt_n = fcnt + FCW'(f_fire);
      if (state == LOAD) begin
         x_addr = XAW'(xcnt);
         f_addr = FAW'(fcnt);
      end else begin
         x_addr = XAW'(idx) + XAW'(step);
         f_addr = FAW'(step);
      end
   end

   sp_mem #(.WIDTH(DW), .SIZE(N)) x_mem (
      .clk(clk), .we(x_fire), .addr(x_addr), .wdata(bus.s_data_in_x), .rdata(x_rd)
   );

   sp_mem #(.WIDTH(DW), .SIZE(M)) f_mem (
      .clk(clk), .we(f_fire), .addr(f_addr), .wdata(bus.s_data_in_f), .rdata(f_rd)
   );

   conv_mac #(.DW(DW), .OW(OW), .RELU(RELU)) mac (
      .clk(clk), .reset(reset), .en(rd_v), .clr(rd_clr), .a(x_rd), .b(f_rd), .y(mac_y)
   );

   // COMPUTE: step 0..M-1 issues tap reads; rd_v/rd_clr travel alongside the
   // 1-cycle memory read so the MAC sees them with the data. The sum settles at
   // step M+1 and is registered to the output, M+2 cycles after the j=0 read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= LOAD;
         xcnt             <= '0;
         fcnt             <= '0;
         idx              <= '0;
         step             <= '0;
         rd_v             <= 1'b0;
         rd_clr           <= 1'b0;
         bus.s_ready_x    <= 1'b0;
         bus.s_ready_f    <= 1'b0;
         bus.m_valid_y    <= 1'b0;
         bus.m_data_out_y <= '0;
      end else begin
         rd_v   <= 1'b0;
         rd_clr <= 1'b0;
         case (state)
            LOAD: begin
               xcnt          <= xcnt_n;
               fcnt          <= fcnt_n;
               bus.s_ready_x <= (xcnt_n < X_FULL);
               bus.s_ready_f <= (fcnt_n < F_FULL);
               if (xcnt == X_FULL && fcnt == F_FULL) begin
                  state <= COMPUTE;
                  idx   <= '0;
                  step  <= '0;
               end
            end
            COMPUTE: begin
               rd_v   <= (step < S_TAPS);
               rd_clr <= (step == '0);
               step   <= step + SW'(1);
               if (step == S_DONE) begin
                  bus.m_valid_y    <= 1'b1;
                  bus.m_data_out_y <= mac_y;
                  state            <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (bus.m_ready_y) begin
                  bus.m_valid_y <= 1'b0;
                  if (idx == I_LAST) begin
                     xcnt          <= '0;
                     fcnt          <= '0;
                     bus.s_ready_x <= 1'b1;
                     bus.s_ready_f <= 1'b1;
                     state         <= LOAD;
                  end else begin
                     idx   <= idx + IW'(1);
                     step  <= '0;
                     state <= COMPUTE;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_n_m.sv
module tb_conv_n_m;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int            sel;
   logic [DW-1:0] xd, fd;
   logic          xv, fv, yr;
   logic          rx, rf, vy;
   int            dy;
   int            n_cur, m_cur, relu_cur;
   int            xs[16];
   int            fs[16];
   int            exp_q[$];
   int            chk, pass;

   conv_n_m_if #(.DW(8), .OW(18)) if0 ();
   conv_n_m_if #(.DW(8), .OW(18)) if1 ();
   conv_n_m_if #(.DW(8), .OW(19)) if2 ();
   conv_n_m_if #(.DW(8), .OW(16)) if3 ();
   conv_n_m_if #(.DW(8), .OW(18)) if4 ();

   conv_n_m #(.DW(8), .N(8),  .M(4), .RELU(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
   conv_n_m #(.DW(8), .N(8),  .M(4), .RELU(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
   conv_n_m #(.DW(8), .N(8),  .M(8), .RELU(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
   conv_n_m #(.DW(8), .N(5),  .M(1), .RELU(0)) u3 (.clk(clk), .reset(reset), .bus(if3));
   conv_n_m #(.DW(8), .N(16), .M(3), .RELU(0)) u4 (.clk(clk), .reset(reset), .bus(if4));

   assign if0.s_data_in_x = xd;  assign if0.s_data_in_f = fd;
   assign if0.s_valid_x = xv && (sel == 0);  assign if0.s_valid_f = fv && (sel == 0);
   assign if0.m_ready_y = yr && (sel == 0);
   assign if1.s_data_in_x = xd;  assign if1.s_data_in_f = fd;
   assign if1.s_valid_x = xv && (sel == 1);  assign if1.s_valid_f = fv && (sel == 1);
   assign if1.m_ready_y = yr && (sel == 1);
   assign if2.s_data_in_x = xd;  assign if2.s_data_in_f = fd;
   assign if2.s_valid_x = xv && (sel == 2);  assign if2.s_valid_f = fv && (sel == 2);
   assign if2.m_ready_y = yr && (sel == 2);
   assign if3.s_data_in_x = xd;  assign if3.s_data_in_f = fd;
   assign if3.s_valid_x = xv && (sel == 3);  assign if3.s_valid_f = fv && (sel == 3);
   assign if3.m_ready_y = yr && (sel == 3);
   assign if4.s_data_in_x = xd;  assign if4.s_data_in_f = fd;
   assign if4.s_valid_x = xv && (sel == 4);  assign if4.s_valid_f = fv && (sel == 4);
   assign if4.m_ready_y = yr && (sel == 4);

   always_comb begin
      rx = 1'b0; rf = 1'b0; vy = 1'b0; dy = 0;
      case (sel)
         0: begin rx = if0.s_ready_x; rf = if0.s_ready_f; vy = if0.m_valid_y; dy = int'($signed(if0.m_data_out_y)); end
         1: begin rx = if1.s_ready_x; rf = if1.s_ready_f; vy = if1.m_valid_y; dy = int'($signed(if1.m_data_out_y)); end
         2: begin rx = if2.s_ready_x; rf = if2.s_ready_f; vy = if2.m_valid_y; dy = int'($signed(if2.m_data_out_y)); end
         3: begin rx = if3.s_ready_x; rf = if3.s_ready_f; vy = if3.m_valid_y; dy = int'($signed(if3.m_data_out_y)); end
         4: begin rx = if4.s_ready_x; rf = if4.s_ready_f; vy = if4.m_valid_y; dy = int'($signed(if4.m_data_out_y)); end
         default: ;
      endcase
   end

   task automatic set_cfg(input int s);
      sel = s;
      case (s)
         0: begin n_cur = 8;  m_cur = 4; relu_cur = 0; end
         1: begin n_cur = 8;  m_cur = 4; relu_cur = 1; end
         2: begin n_cur = 8;  m_cur = 8; relu_cur = 0; end
         3: begin n_cur = 5;  m_cur = 1; relu_cur = 0; end
         default: begin n_cur = 16; m_cur = 3; relu_cur = 0; end
      endcase
   endtask

   task automatic randomize_frame();
      for (int k = 0; k < 16; k++) begin
         xs[k] = int'($urandom_range(255, 0)) - 128;
         fs[k] = int'($urandom_range(255, 0)) - 128;
      end
   endtask

   // Reference: valid-mode convolution straight from the definition.
   task automatic push_model();
      int s;
      for (int i = 0; i <= n_cur - m_cur; i++) begin
         s = 0;
         for (int j = 0; j < m_cur; j++) s += xs[i+j] * fs[j];
         if (relu_cur != 0 && s < 0) s = 0;
         exp_q.push_back(s);
      end
   endtask

   task automatic feed_x(input int gap, input int junk);
      int t;
      for (int k = 0; k < n_cur; k++) begin
         repeat ($urandom_range(gap, 0)) begin @(negedge clk); xv = 1'b0; end
         @(negedge clk);
         xv = 1'b1; xd = DW'(xs[k]);
         t = 0;
         while (!rx && t < 500) begin @(negedge clk); t++; end
         if (t >= 500) begin
            chk++; $display("FAIL x_accept_timeout: ready_x=%b after %0d cycles, required 1", rx, t);
            xv = 1'b0; return;
         end
      end
      @(negedge clk);
      if (junk == 0) xv = 1'b0; else xd = 8'h5A;
      chk++;
      if (rx !== 1'b0) $display("FAIL ready_x_drop: ready_x=%b, required 0", rx); else pass++;
      if (junk != 0) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk++;
            if (rx !== 1'b0) $display("FAIL no_extra_x: ready_x=%b with valid held, required 0", rx); else pass++;
         end
      end
      xv = 1'b0;
   endtask

   task automatic feed_f(input int gap, input int junk);
      int t;
      for (int k = 0; k < m_cur; k++) begin
         repeat ($urandom_range(gap, 0)) begin @(negedge clk); fv = 1'b0; end
         @(negedge clk);
         fv = 1'b1; fd = DW'(fs[k]);
         t = 0;
         while (!rf && t < 500) begin @(negedge clk); t++; end
         if (t >= 500) begin
            chk++; $display("FAIL f_accept_timeout: ready_f=%b after %0d cycles, required 1", rf, t);
            fv = 1'b0; return;
         end
      end
      @(negedge clk);
      if (junk == 0) fv = 1'b0; else fd = 8'hA5;
      chk++;
      if (rf !== 1'b0) $display("FAIL ready_f_drop: ready_f=%b, required 0", rf); else pass++;
      if (junk != 0) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk++;
            if (rf !== 1'b0) $display("FAIL no_extra_f: ready_f=%b with valid held, required 0", rf); else pass++;
         end
      end
      fv = 1'b0;
   endtask

   task automatic collect(input int count, input int bp);
      int t, got, gap, d0, e;
      got = 0; t = 0; gap = 0;
      yr = (bp == 0);
      while (got < count && t < 3000) begin
         @(negedge clk); t++; gap++;
         if (vy === 1'b1) begin
            if (got > 0) begin
               chk++;
               if (gap !== m_cur + 2) $display("FAIL y_latency: %0d cycles, required %0d", gap, m_cur + 2);
               else pass++;
            end
            if (bp > 0) begin
               d0 = dy;
               for (int c = 0; c < bp; c++) begin
                  @(negedge clk); t++;
                  chk++;
                  if (vy !== 1'b1 || dy !== d0 || rx !== 1'b0 || rf !== 1'b0)
                     $display("FAIL bp_hold: valid=%b data=%0d rx=%b rf=%b, required 1 %0d 0 0", vy, dy, rx, rf, d0);
                  else pass++;
               end
               yr = 1'b1;
            end
            chk++;
            if (exp_q.size() == 0) $display("FAIL extra_output: got %0d, required none", dy);
            else begin
               e = exp_q.pop_front();
               if (dy !== e) $display("FAIL y_value[%0d]: got %0d, required %0d", got, dy, e);
               else pass++;
            end
            got++;
            @(negedge clk); t++; gap = 0;
            if (bp > 0) yr = 1'b0;
            chk++;
            if (vy !== 1'b0) $display("FAIL valid_drop: valid=%b, required 0", vy); else pass++;
            if (got == count) begin
               chk++;
               if (rx !== 1'b1 || rf !== 1'b1)
                  $display("FAIL ready_reassert: rx=%b rf=%b, required 1 1", rx, rf);
               else pass++;
            end
         end
      end
      if (got < count) begin
         chk++; $display("FAIL y_timeout: got %0d outputs, required %0d", got, count);
      end
      yr = 1'b0;
   endtask

   task automatic run_frame(input int gx, input int gf, input int bp, input int junk);
      push_model();
      fork
         feed_x(gx, junk);
         feed_f(gf, junk);
         collect(n_cur - m_cur + 1, bp);
      join
   endtask

   task automatic test_reset();
      set_cfg(0);
      #1 reset = 1'b1;
      #2;
      chk++;
      if (rx !== 1'b0 || rf !== 1'b0 || vy !== 1'b0 || dy !== 0)
         $display("FAIL reset_outputs: rx=%b rf=%b vy=%b y=%0d, required all 0", rx, rf, vy, dy);
      else pass++;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk++;
      if (rx !== 1'b1 || rf !== 1'b1) $display("FAIL ready_after_reset: rx=%b rf=%b, required 1 1", rx, rf);
      else pass++;
      // partial frame, then reset mid-LOAD
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         xv = 1'b1; fv = 1'b1; xd = DW'(50 + k); fd = DW'(60 + k);
      end
      @(negedge clk);
      xv = 1'b0; fv = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk++;
      if (rx !== 1'b0 || rf !== 1'b0 || vy !== 1'b0 || dy !== 0)
         $display("FAIL reset_mid_load: rx=%b rf=%b vy=%b y=%0d, required all 0", rx, rf, vy, dy);
      else pass++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk++;
      if (rx !== 1'b1 || rf !== 1'b1) $display("FAIL ready_after_load_reset: rx=%b rf=%b, required 1 1", rx, rf);
      else pass++;
   endtask

   task automatic test_basic();
      set_cfg(0);
      for (int k = 0; k < 8; k++) begin xs[k] = k + 1; fs[k] = 1; end
      run_frame(0, 0, 0, 0);
   endtask

   task automatic test_reset_compute();
      int bad;
      set_cfg(0);
      randomize_frame();
      fork
         feed_x(0, 0);
         feed_f(0, 0);
      join
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk++;
      if (rx !== 1'b0 || rf !== 1'b0 || vy !== 1'b0 || dy !== 0)
         $display("FAIL reset_mid_compute: rx=%b rf=%b vy=%b y=%0d, required all 0", rx, rf, vy, dy);
      else pass++;
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (vy !== 1'b0 || rx !== 1'b1 || rf !== 1'b1) bad++;
      end
      chk++;
      if (bad !== 0) $display("FAIL stale_frame: %0d cycles with stale output or ready low, required 0", bad);
      else pass++;
   endtask

   task automatic test_extremes();
      set_cfg(0);
      for (int k = 0; k < 8; k++) begin xs[k] = -128; fs[k] = -128; end
      run_frame(0, 0, 0, 0);
      for (int k = 0; k < 8; k++) fs[k] = 127;
      run_frame(0, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      set_cfg(0);
      randomize_frame();
      run_frame(0, 0, 5, 0);
   endtask

   task automatic test_interleaved();
      set_cfg(0);
      randomize_frame();
      run_frame(4, 1, 0, 1);
   endtask

   task automatic test_relu();
      set_cfg(1);
      for (int k = 0; k < 8; k++) begin
         xs[k] = (k % 2 == 0) ? k + 1 : -(k + 1);
         fs[k] = (k == 0) ? 1 : 0;
      end
      run_frame(1, 1, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int s = 2; s <= 4; s++) begin
         set_cfg(s);
         randomize_frame();
         run_frame(1, 1, 0, 0);
         randomize_frame();
         run_frame(0, 0, 2, 0);
      end
   endtask

   initial begin
      chk = 0; pass = 0;
      xv = 1'b0; fv = 1'b0; yr = 1'b0; xd = '0; fd = '0;
      reset = 1'b0;
      sel = 0;
      test_reset();
      test_basic();
      test_reset_compute();
      test_extremes();
      test_backpressure();
      test_interleaved();
      test_relu();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass, chk);
      $fatal(1);
   end
endmodule
